has_service_arbiter: RTL

HAS_SERVICE_ARBITER -- requirements
Module: has_service_arbiter

---
 rtl/has_service_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/has_service_arbiter.sv
// Six-way service arbiter for a building controller.
// The fire alarm has absolute priority. Starved requesters beat ordinary ones.
// Each grant lasts at most HOLD_MAX cycles and is followed by one GAP cycle
// before arbitration can happen again.
module has_service_arbiter #(
   parameter int HOLD_MAX   = 8,
   parameter int WAIT_MAX   = 12,
   parameter int URGENT_IDX = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] req,
   output logic [5:0] gnt,
   output logic [2:0] display,
   output logic       busy,
   output logic       forced
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);
   localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);
   localparam logic [2:0] URG      = 3'(URGENT_IDX);

   state_t          state_q, state_d;
   logic [5:0]      gnt_q, gnt_d;
   logic [2:0]      disp_q, disp_d;
   logic            busy_q, busy_d;
   logic            forced_q, forced_d;
   logic [2:0]      gidx_q, gidx_d;
   logic [2:0]      last_q, last_d;
   logic [3:0]      hold_q, hold_d;
   logic [5:0][3:0] wait_q, wait_d;

   logic [5:0] starved;
   logic [3:0] pick_s, pick_n;
   logic [2:0] win;
   logic       hold_to, preempt, release_c;

   // Round-robin search: the first set bit of mask at or after (last+1) mod 6.
   // Result is {found, index}.
   function automatic logic [3:0] rr_pick(input logic [5:0] mask, input logic [2:0] last);
      logic [3:0] r;
      int         idx;
      r = '0;
      for (int k = 5; k >= 0; k--) begin
         idx = (int'(last) + 1 + k) % 6;
         if (mask[idx]) r = {1'b1, 3'(idx)};
      end
      return r;
   endfunction

   // Next-state logic: arbitration, grant hold and release, and the wait counters.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      disp_d   = disp_q;
      busy_d   = busy_q;
      forced_d = 1'b0;
      gidx_d   = gidx_q;
      last_d   = last_q;
      hold_d   = hold_q;
      wait_d   = wait_q;

      // A requester counts as starved only if it is still requesting at this edge.
      for (int i = 0; i < 6; i++)
         starved[i] = req[i] && (wait_q[i] == WAIT_LIM);
      pick_s = rr_pick(starved, last_q);
      pick_n = rr_pick(req, last_q);
      if (req[URG])      win = URG;
      else if (pick_s[3]) win = pick_s[2:0];
      else                win = pick_n[2:0];

      hold_to   = (hold_q == HOLD_LIM);
      preempt   = req[URG] && (gidx_q != URG);
      release_c = !req[gidx_q] || hold_to || preempt;

      case (state_q)
         GRANT: begin
            if (release_c) begin
               state_d  = GAP;
               gnt_d    = '0;
               disp_d   = '0;
               busy_d   = 1'b0;
               hold_d   = '0;
               forced_d = hold_to || preempt;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         GAP: state_d = IDLE;
         // IDLE, and the unused encoding, which behaves as IDLE.
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            disp_d  = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
            if (|req) begin
               state_d = GRANT;
               gnt_d   = 6'd1 << win;
               disp_d  = win + 3'd1;
               busy_d  = 1'b1;
               gidx_d  = win;
               last_d  = win;
               hold_d  = 4'd1;
            end
         end
      endcase

      // Wait counters follow the grant currently on the outputs.
      for (int i = 0; i < 6; i++) begin
         if (!req[i] || gnt_q[i])       wait_d[i] = '0;
         else if (wait_q[i] != WAIT_LIM) wait_d[i] = wait_q[i] + 4'd1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         disp_q   <= '0;
         busy_q   <= 1'b0;
         forced_q <= 1'b0;
         gidx_q   <= '0;
         last_q   <= 3'd5;
         hold_q   <= '0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         disp_q   <= disp_d;
         busy_q   <= busy_d;
         forced_q <= forced_d;
         gidx_q   <= gidx_d;
         last_q   <= last_d;
         hold_q   <= hold_d;
         wait_q   <= wait_d;
      end
   end

   assign gnt     = gnt_q;
   assign display = disp_q;
   assign busy    = busy_q;
   assign forced  = forced_q;

endmodule
